wr_ctrl_sync: RTL and testbench



---
 rtl/wr_ctrl_sync.sv | 117 +++++++++++
 tb/tb_wr_ctrl_sync.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module   : wr_ctrl_sync
//  Brief    : Write-side controller for the asynchronous FIFO (generation 2).
//             Owns the binary/Gray write pointers and the RAM write port,
//             synchronises the read Gray pointer into w_clk and produces
//             registered full, almost-full, fill level and sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module wr_ctrl_sync #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2**ADDR_WIDTH - 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam logic [ADDR_WIDTH:0] C_AF_THRESH = (ADDR_WIDTH+1)'(AF_THRESH);

    logic [ADDR_WIDTH:0]                    r_wbin;
    logic [SYNC_STAGES-1:0][ADDR_WIDTH:0]   r_sync;

    logic                w_accept;
    logic [ADDR_WIDTH:0] w_wbin_next;
    logic [ADDR_WIDTH:0] w_wgray_next;
    logic [ADDR_WIDTH:0] w_rq;
    logic [ADDR_WIDTH:0] w_rbin_s;
    logic [ADDR_WIDTH:0] w_full_cmp;
    logic [ADDR_WIDTH:0] w_level_next;

    // Write strobe: only while out of reset and not full, so a full FIFO
    // never sees a RAM write and the pointer cannot overrun the reader.
    assign w_accept = winc & ~wfull;
    assign wen      = w_accept & w_rst;
    assign waddr    = r_wbin[ADDR_WIDTH-1:0];

    // Next pointers; equal to the current ones when nothing is accepted.
    assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Synchronised read pointer and its binary equivalent.
    assign w_rq = r_sync[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin_s = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            w_rbin_s[i] = ^(w_rq >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits inverted, the rest equal.
    assign w_full_cmp   = {~w_rq[ADDR_WIDTH:ADDR_WIDTH-1], w_rq[ADDR_WIDTH-2:0]};
    assign w_level_next = w_wbin_next - w_rbin_s;

    // Read-pointer synchroniser chain into the w_clk domain.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= r_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Write pointers advance together so w_ptr is always gray(r_wbin).
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_wbin <= '0;
            w_ptr  <= '0;
        end else begin
            r_wbin <= w_wbin_next;
            w_ptr  <= w_wgray_next;
        end
    end

    // Status flags are recomputed on every edge from the next write pointer
    // and the synchronised read pointer, so a same-edge write and read cancel.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wfull        <= (w_wgray_next == w_full_cmp);
            wlevel       <= w_level_next;
            walmost_full <= (w_level_next >= C_AF_THRESH);
        end
    end

    // Sticky overflow: a set on the same edge as a clear takes priority.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (ovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wr_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wr_ctrl_sync
//  Brief    : Self-checking bench for wr_ctrl_sync: a directed vector table,
//             hand-written reset/tracking sequences and randomised traffic
//             compared against a count-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wr_ctrl_sync;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int SS    = 2;
    localparam int AF    = 14;

    logic          w_clk = 1'b0;
    logic          w_rst = 1'b0;
    logic          winc = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   r_ptr = '0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   w_ptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    wr_ctrl_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AF_THRESH(AF)) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .winc         (winc),
        .ovf_clr      (ovf_clr),
        .r_ptr        (r_ptr),
        .wen          (wen),
        .waddr        (waddr),
        .w_ptr        (w_ptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 w_clk = ~w_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain write/read counts; the synchroniser is a
    // delay line of read counts seen at past edges.
    int m_wcnt;
    int m_level;
    bit m_full;
    bit m_af;
    bit m_ovf;
    int m_rs[SS];
    int wen_pulses;
    bit last_wen;

    typedef struct {
        bit          wi;
        bit          clr;
        int          rc;
        bit          exp_wen;
        bit          exp_full;
        bit          exp_af;
        bit          exp_ovf;
        int          exp_level;
        logic [AW:0] exp_wptr;
    } vec_t;

    vec_t tbl[25];

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wcnt  = 0;
        m_level = 0;
        m_full  = 0;
        m_af    = 0;
        m_ovf   = 0;
        for (int i = 0; i < SS; i++) m_rs[i] = 0;
    endtask

    // One clock: drive on negedge, check combinational outputs, clock,
    // advance the model, check registered outputs.
    task automatic step(input bit wi, input bit clr, input int rc);
        bit acc;
        int rseen;
        @(negedge w_clk);
        winc    = wi;
        ovf_clr = clr;
        r_ptr   = gray(rc);
        #1;
        check("wen", wen, wi && !m_full);
        check("waddr", waddr, m_wcnt % DEPTH);
        last_wen = (wen === 1'b1);
        if (last_wen) wen_pulses++;
        @(posedge w_clk);
        acc = wi && !m_full;
        if (wi && m_full) m_ovf = 1;
        else if (clr)     m_ovf = 0;
        if (acc) m_wcnt++;
        rseen   = m_rs[SS-1];
        m_level = m_wcnt - rseen;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AF);
        for (int i = SS-1; i > 0; i--) m_rs[i] = m_rs[i-1];
        m_rs[0] = rc;
        #1;
        check("wfull", wfull, m_full);
        check("wlevel", wlevel, m_level);
        check("walmost_full", walmost_full, m_af);
        check("woverflow", woverflow, m_ovf);
        check("w_ptr", w_ptr, gray(m_wcnt));
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst   = 1'b0;
        winc    = 1'b0;
        ovf_clr = 1'b0;
        r_ptr   = '0;
        @(negedge w_clk);
        w_rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int rcnt;
        bit saw_full;

        // Directed table: fill, overflow, clear, one read, refill.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{wi:1, clr:0, rc:0, exp_wen:1, exp_full:(i == 15), exp_af:(i + 1 >= 14),
                       exp_ovf:0, exp_level:i + 1, exp_wptr:gray(i + 1)};
        end
        for (int i = 16; i < 19; i++) begin
            tbl[i] = '{wi:1, clr:0, rc:0, exp_wen:0, exp_full:1, exp_af:1,
                       exp_ovf:1, exp_level:16, exp_wptr:5'b11000};
        end
        tbl[19] = '{wi:0, clr:1, rc:0, exp_wen:0, exp_full:1, exp_af:1, exp_ovf:0, exp_level:16, exp_wptr:5'b11000};
        tbl[20] = '{wi:0, clr:0, rc:1, exp_wen:0, exp_full:1, exp_af:1, exp_ovf:0, exp_level:16, exp_wptr:5'b11000};
        tbl[21] = '{wi:0, clr:0, rc:1, exp_wen:0, exp_full:1, exp_af:1, exp_ovf:0, exp_level:16, exp_wptr:5'b11000};
        tbl[22] = '{wi:0, clr:0, rc:1, exp_wen:0, exp_full:0, exp_af:1, exp_ovf:0, exp_level:15, exp_wptr:5'b11000};
        tbl[23] = '{wi:0, clr:0, rc:1, exp_wen:0, exp_full:0, exp_af:1, exp_ovf:0, exp_level:15, exp_wptr:5'b11000};
        tbl[24] = '{wi:1, clr:0, rc:1, exp_wen:1, exp_full:1, exp_af:1, exp_ovf:0, exp_level:16, exp_wptr:5'b11001};

        // Reset asserted: strobe must stay low even with a request pending.
        model_reset();
        wen_pulses = 0;
        winc = 1'b1;
        repeat (3) @(posedge w_clk);
        #1;
        check("rst_wen", wen, 0);
        check("rst_wptr", w_ptr, 0);
        check("rst_wfull", wfull, 0);
        @(negedge w_clk);
        w_rst = 1'b1;
        winc  = 1'b0;

        // Idle after reset: defaults.
        step(0, 0, 0);
        check("idle_waddr", waddr, 0);
        check("idle_wlevel", wlevel, 0);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].wi, tbl[i].clr, tbl[i].rc);
            check("tbl_wen", last_wen, tbl[i].exp_wen);
            check("tbl_wfull", wfull, tbl[i].exp_full);
            check("tbl_wlevel", wlevel, tbl[i].exp_level);
            check("tbl_af", walmost_full, tbl[i].exp_af);
            check("tbl_ovf", woverflow, tbl[i].exp_ovf);
            check("tbl_wptr", w_ptr, tbl[i].exp_wptr);
            if (i == 15) begin
                check("fill_wen_pulses", wen_pulses, 16);
                check("fill_waddr", waddr, 0);
            end
        end

        // Reader trails the writer by three words; never full, level steady.
        do_reset();
        saw_full = 0;
        for (int k = 0; k < 40; k++) begin
            rcnt = (m_wcnt >= 3) ? m_wcnt - 3 : 0;
            step(1, 0, rcnt);
            if (wfull === 1'b1) saw_full = 1;
        end
        check("track_no_full", saw_full, 0);
        check("track_level", wlevel, 6);
        check("track_wptr", w_ptr, gray(40));

        // Asynchronous reset mid-cycle at level 9.
        do_reset();
        for (int k = 0; k < 9; k++) step(1, 0, 0);
        check("pre_rst_level", wlevel, 9);
        @(negedge w_clk);
        winc = 1'b1;
        #2;
        w_rst = 1'b0;
        #1;
        check("arst_wen", wen, 0);
        check("arst_wlevel", wlevel, 0);
        check("arst_wptr", w_ptr, 0);
        check("arst_waddr", waddr, 0);
        check("arst_af", walmost_full, 0);
        model_reset();
        @(negedge w_clk);
        w_rst = 1'b1;
        winc  = 1'b0;
        step(1, 0, 0);
        check("post_rst_wptr", w_ptr, 5'b00001);

        // Randomised traffic against the model.
        do_reset();
        rcnt = 0;
        for (int k = 0; k < 400; k++) begin
            if (rcnt < m_wcnt && $urandom_range(0, 99) < 40) rcnt++;
            step($urandom_range(0, 99) < 70, $urandom_range(0, 19) == 0, rcnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
